// File: rtl/packet_check_register.sv
// packet_check_register
//   Router input packet register. Takes a header / payload / check-byte
//   stream, forwards every accepted byte to the router FIFO through a small
//   skid buffer that soaks up FIFO-full stalls, and checks the packet's
//   checksum and payload length once the whole packet has been written out.
//
// Ports
//   clk                 clock, all state on rising edge
//   reset               synchronous active-high reset
//   i_Data_Valid        i_Input_Data carries a byte this cycle
//   i_Sig_Packet_Valid  high for header/payload, low for the check byte
//   i_Input_Data        incoming byte
//   i_Sig_Fifo_Full     downstream FIFO cannot accept a write
//   o_Busy              source must hold off (combinational)
//   o_Output_Write      registered FIFO write strobe
//   o_Output_Data       registered FIFO write data
//   o_Header            header of the current / last packet
//   o_Sig_Parity_Done   one-cycle pulse: packet forwarded and checked
//   o_Error             checksum mismatch on the last packet
//   o_Length_Error      payload count differed from header length field
//   o_Overflow          sticky: a byte was presented while busy
module packet_check_register #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 2,
  parameter int SKID_DEPTH = 4,
  parameter int CHECK_MODE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_Data_Valid,
  input  logic                  i_Sig_Packet_Valid,
  input  logic [DATA_WIDTH-1:0] i_Input_Data,
  input  logic                  i_Sig_Fifo_Full,
  output logic                  o_Busy,
  output logic                  o_Output_Write,
  output logic [DATA_WIDTH-1:0] o_Output_Data,
  output logic [DATA_WIDTH-1:0] o_Header,
  output logic                  o_Sig_Parity_Done,
  output logic                  o_Error,
  output logic                  o_Length_Error,
  output logic                  o_Overflow
);

  localparam int PW = $clog2(SKID_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = DATA_WIDTH - ADDR_BITS;
  // One above the largest encodable length, so overlong packets never wrap
  // back into a matching count.
  localparam logic [LW:0] CNT_MAX = {1'b1, {LW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_check;
  logic [LW:0]           r_len_cnt;
  logic [DATA_WIDTH-1:0] r_header;
  logic                  r_out_write;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_error;
  logic                  r_len_error;
  logic                  r_overflow;

  logic                  w_busy;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_acc_upd;

  assign w_busy   = (r_count == CW'(SKID_DEPTH)) || (r_state == S_DRAIN) || (r_state == S_DONE);
  assign w_accept = i_Data_Valid && !w_busy;
  // Header in IDLE, or any byte (payload or check) in PAYLOAD. A check byte
  // arriving in IDLE is dropped without being forwarded.
  assign w_push   = w_accept && ((r_state == S_IDLE && i_Sig_Packet_Valid) || r_state == S_PAYLOAD);
  assign w_pop    = (r_count != '0) && !i_Sig_Fifo_Full;

  generate
    if (CHECK_MODE == 1) begin : g_sum
      assign w_acc_upd = r_acc + i_Input_Data;
    end else begin : g_xor
      assign w_acc_upd = r_acc ^ i_Input_Data;
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept && i_Sig_Packet_Valid) w_state_next = S_PAYLOAD;
      S_PAYLOAD: if (w_accept && !i_Sig_Packet_Valid) w_state_next = S_DRAIN;
      // Completion waits until the check byte has actually been written out.
      S_DRAIN:   if (r_count == '0 && !r_out_write) w_state_next = S_DONE;
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Skid storage: plain array, no reset, so it maps onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_Input_Data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_acc       <= '0;
      r_check     <= '0;
      r_len_cnt   <= '0;
      r_header    <= '0;
      r_out_write <= 1'b0;
      r_out_data  <= '0;
      r_error     <= 1'b0;
      r_len_error <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      r_out_write <= w_pop;
      if (w_pop) r_out_data <= r_mem[r_rd_ptr];

      if (i_Data_Valid && w_busy) r_overflow <= 1'b1;

      if (w_accept && r_state == S_IDLE && i_Sig_Packet_Valid) begin
        r_header    <= i_Input_Data;
        r_acc       <= i_Input_Data;
        r_len_cnt   <= '0;
        r_error     <= 1'b0;
        r_len_error <= 1'b0;
      end

      if (w_accept && r_state == S_PAYLOAD) begin
        if (i_Sig_Packet_Valid) begin
          r_acc <= w_acc_upd;
          if (r_len_cnt != CNT_MAX) r_len_cnt <= r_len_cnt + 1'b1;
        end else begin
          r_check <= i_Input_Data;
        end
      end

      if (r_state == S_DONE) begin
        r_error     <= (r_acc != r_check);
        r_len_error <= (r_len_cnt != {1'b0, r_header[DATA_WIDTH-1:ADDR_BITS]});
      end
    end
  end

  assign o_Busy            = w_busy;
  assign o_Output_Write    = r_out_write;
  assign o_Output_Data     = r_out_data;
  assign o_Header          = r_header;
  assign o_Sig_Parity_Done = (r_state == S_DONE);
  assign o_Error           = r_error;
  assign o_Length_Error    = r_len_error;
  assign o_Overflow        = r_overflow;

endmodule

// File: tb/tb_packet_check_register.sv
// Directed bench for packet_check_register. Two instances share one stimulus
// stream: one in XOR checksum mode, one in modular-sum mode. Accepted bytes
// are queued as expected FIFO writes and matched as they come out.
module tb_packet_check_register;

  logic       clk = 1'b0;
  logic       reset;
  logic       dv;
  logic       pv;
  logic [7:0] din;
  logic       full;

  logic       x_busy, x_wr, x_done, x_err, x_lerr, x_ovf;
  logic [7:0] x_data, x_hdr;
  logic       s_busy, s_wr, s_done, s_err, s_lerr, s_ovf;
  logic [7:0] s_data, s_hdr;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done_x = 0;

  logic [7:0] qx[$];
  logic [7:0] qs[$];

  // Reference model state
  bit         in_pkt = 0;
  logic [7:0] m_hdr, m_accx, m_accs;
  int         m_cnt;
  bit         e_err_x, e_err_s, e_len;

  always #5 clk = ~clk;

  packet_check_register #(.DATA_WIDTH(8), .ADDR_BITS(2), .SKID_DEPTH(4), .CHECK_MODE(0)) u_xor (
    .clk(clk), .reset(reset), .i_Data_Valid(dv), .i_Sig_Packet_Valid(pv),
    .i_Input_Data(din), .i_Sig_Fifo_Full(full), .o_Busy(x_busy),
    .o_Output_Write(x_wr), .o_Output_Data(x_data), .o_Header(x_hdr),
    .o_Sig_Parity_Done(x_done), .o_Error(x_err), .o_Length_Error(x_lerr),
    .o_Overflow(x_ovf)
  );

  packet_check_register #(.DATA_WIDTH(8), .ADDR_BITS(2), .SKID_DEPTH(4), .CHECK_MODE(1)) u_sum (
    .clk(clk), .reset(reset), .i_Data_Valid(dv), .i_Sig_Packet_Valid(pv),
    .i_Input_Data(din), .i_Sig_Fifo_Full(full), .o_Busy(s_busy),
    .o_Output_Write(s_wr), .o_Output_Data(s_data), .o_Header(s_hdr),
    .o_Sig_Parity_Done(s_done), .o_Error(s_err), .o_Length_Error(s_lerr),
    .o_Overflow(s_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every FIFO write must match the oldest expected byte.
  always @(negedge clk) begin
    if (x_wr) begin
      if (qx.size() == 0) chk("xor_unexpected_write", {24'd0, x_data}, 32'hFFFF_FFFF);
      else chk("xor_write", {24'd0, x_data}, {24'd0, qx.pop_front()});
    end
    if (s_wr) begin
      if (qs.size() == 0) chk("sum_unexpected_write", {24'd0, s_data}, 32'hFFFF_FFFF);
      else chk("sum_write", {24'd0, s_data}, {24'd0, qs.pop_front()});
    end
    if (x_done) n_done_x++;
  end

  // Drive one byte for one cycle. keep=1 means the byte will be accepted and
  // forwarded, so it is queued and folded into the reference model.
  task automatic put(input bit p, input logic [7:0] d, input bit keep);
    dv = 1'b1; pv = p; din = d;
    if (keep) begin
      qx.push_back(d);
      qs.push_back(d);
      if (!in_pkt) begin
        in_pkt = 1; m_hdr = d; m_accx = d; m_accs = d; m_cnt = 0;
      end else if (p) begin
        m_accx = m_accx ^ d;
        m_accs = m_accs + d;
        m_cnt++;
      end else begin
        e_err_x = (m_accx != d);
        e_err_s = (m_accs != d);
        e_len   = (m_cnt != int'(m_hdr >> 2));
        in_pkt  = 0;
      end
    end
    @(posedge clk); #1;
    dv = 1'b0; pv = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (x_done) seen = 1;
    end
    n_cmp++;
    assert (seen) else begin
      n_bad++;
      $error("FAIL %s_done_timeout observed=0 expected=1", tag);
    end
    if (seen) begin
      chk({tag, "_sum_done"}, {31'd0, s_done}, 32'd1);
      chk({tag, "_all_written"}, qx.size() + qs.size(), 32'd0);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, {31'd0, x_done}, 32'd0);
      chk({tag, "_xor_err"}, {31'd0, x_err}, {31'd0, e_err_x});
      chk({tag, "_sum_err"}, {31'd0, s_err}, {31'd0, e_err_s});
      chk({tag, "_xor_len_err"}, {31'd0, x_lerr}, {31'd0, e_len});
      chk({tag, "_sum_len_err"}, {31'd0, s_lerr}, {31'd0, e_len});
      $display("packet %s: hdr=%h xor_err=%0b sum_err=%0b len_err=%0b", tag, x_hdr, x_err, s_err, x_lerr);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr"},   {31'd0, x_wr},   32'd0);
    chk({tag, "_data"}, {24'd0, x_data}, 32'd0);
    chk({tag, "_hdr"},  {24'd0, x_hdr},  32'd0);
    chk({tag, "_done"}, {31'd0, x_done}, 32'd0);
    chk({tag, "_err"},  {31'd0, x_err},  32'd0);
    chk({tag, "_lerr"}, {31'd0, x_lerr}, 32'd0);
    chk({tag, "_ovf"},  {31'd0, x_ovf},  32'd0);
    chk({tag, "_busy"}, {31'd0, x_busy}, 32'd0);
  endtask

  int done_before;

  initial begin
    reset = 1'b1; dv = 1'b0; pv = 1'b0; din = '0; full = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // Check byte with no header in IDLE: dropped, nothing forwarded.
    put(1'b0, 8'h55, 1'b0);

    // XOR-good packet, LEN=3
    put(1, 8'h0D, 1); put(1, 8'h11, 1); put(1, 8'h22, 1); put(1, 8'h33, 1);
    put(0, 8'h0D, 1);
    wait_done("p1_xor_ok");

    // Bad check byte
    put(1, 8'h0D, 1); put(1, 8'h11, 1); put(1, 8'h22, 1); put(1, 8'h33, 1);
    put(0, 8'hFF, 1);
    wait_done("p2_bad_check");

    // Sum-mode good packet; error flags must clear on header acceptance
    put(1, 8'h08, 1);
    @(negedge clk);
    chk("p3_err_cleared", {31'd0, x_err}, 32'd0);
    chk("p3_header", {24'd0, x_hdr}, 32'h08);
    put(1, 8'hF0, 1); put(1, 8'h20, 1);
    put(0, 8'h18, 1);
    wait_done("p3_sum_ok");

    put(1, 8'h08, 1); put(1, 8'hF0, 1); put(1, 8'h20, 1);
    put(0, 8'h19, 1);
    wait_done("p4_sum_bad");

    // LEN=2 with three payload bytes
    put(1, 8'h08, 1); put(1, 8'h01, 1); put(1, 8'h02, 1); put(1, 8'h03, 1);
    put(0, 8'h08, 1);
    wait_done("p5_overlong");

    // Stall: FIFO full while 4 bytes are accepted, then one extra byte
    full = 1'b1;
    put(1, 8'h14, 1); put(1, 8'hA1, 1); put(1, 8'hA2, 1); put(1, 8'hA3, 1);
    @(negedge clk);
    chk("p6_busy_full", {31'd0, x_busy}, 32'd1);
    chk("p6_no_write", {31'd0, x_wr}, 32'd0);
    put(1, 8'hEE, 0);
    @(negedge clk);
    chk("p6_overflow", {31'd0, x_ovf}, 32'd1);
    repeat (4) @(posedge clk);
    #1 full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    put(1, 8'hA4, 1); put(1, 8'hA5, 1);
    put(0, 8'h5A, 1);
    wait_done("p6_stall");
    chk("p6_overflow_sticky", {31'd0, x_ovf}, 32'd1);

    // Reset mid-payload with three bytes held in the skid buffer
    full = 1'b1;
    put(1, 8'h0D, 0); put(1, 8'h11, 0); put(1, 8'h22, 0);
    reset = 1'b1; full = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_all_zero("mid_reset");
    done_before = n_done_x;
    repeat (6) @(negedge clk);
    chk("mid_reset_no_done", n_done_x, done_before);

    put(1, 8'h0D, 1); put(1, 8'h11, 1); put(1, 8'h22, 1); put(1, 8'h33, 1);
    put(0, 8'h0D, 1);
    wait_done("p8_after_reset");

    // Zero-length packet: checksum is the header itself
    put(1, 8'h01, 1);
    put(0, 8'h01, 1);
    wait_done("p9_zero_len");

    chk("done_pulse_count", n_done_x, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/packet_check_register.md
Name: packet_check_register

Overview:
- Parametrised successor to the router input packet register.
- Accepts a byte stream framed by packet-valid (header, payload bytes, then one check byte sent with packet-valid low) and forwards every byte to the router FIFO through an internal skid buffer that absorbs FIFO-full stalls.
- Accumulates a selectable checksum (XOR or modular sum) over header and payload.
- Checks payload length against the header length field and reports checksum and length errors at end of packet.

Parameters:
DATA_WIDTH, 8, width of header, payload, check byte and checksum
ADDR_BITS, 2, low header bits used as destination; header[DATA_WIDTH-1:ADDR_BITS] is payload length LEN
SKID_DEPTH, 4, skid buffer entries (power of two, >=2)
CHECK_MODE, 0, 0 = XOR parity; 1 = sum modulo 2^DATA_WIDTH

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
i_Data_Valid  input  1  i_Input_Data carries a byte this cycle
i_Sig_Packet_Valid  input  1  high for header/payload bytes, low for the check byte
i_Input_Data  input  DATA_WIDTH  incoming byte
i_Sig_Fifo_Full  input  1  downstream FIFO cannot accept a write
o_Busy  output  1  source must hold off; combinational
o_Output_Write  output  1  registered write strobe to FIFO
o_Output_Data  output  DATA_WIDTH  registered byte to FIFO
o_Header  output  DATA_WIDTH  captured header of current/last packet
o_Sig_Parity_Done  output  1  one-cycle pulse, packet fully forwarded and checked
o_Error  output  1  checksum mismatch of last packet
o_Length_Error  output  1  payload count != LEN for last packet
o_Overflow  output  1  sticky: byte presented while o_Busy

Behaviour:
- Reset (sync, high) clears the following: FSM to IDLE, skid emptied, accumulator/count/o_Header to 0, all outputs 0. Reset mid-packet discards buffered bytes. No partial completion pulse is issued.
- Accept = i_Data_Valid && !o_Busy.
- o_Busy = (skid count == SKID_DEPTH) || state in {DRAIN, DONE}.
- A valid byte while o_Busy is dropped and sets o_Overflow. o_Overflow is cleared only by reset.
- FSM IDLE:
  - Accept with packet-valid high captures the header: o_Header <= byte, accumulator <= byte, count <= 0, o_Error/o_Length_Error cleared, byte pushed, next state PAYLOAD.
  - Accept with packet-valid low is dropped silently (no push).
- FSM PAYLOAD:
  - Accept with packet-valid high pushes the byte, sets accumulator <= acc XOR byte (mode 0) or acc + byte mod 2^W (mode 1), and increments count. Count saturates at 2^(W-ADDR_BITS)-1+1 (one above max LEN) so overlong packets still flag.
  - Accept with packet-valid low is the check byte: captured, pushed, next state DRAIN.
- FSM DRAIN: wait until skid empty and no write in flight, then go to DONE.
- FSM DONE (one cycle):
  - o_Sig_Parity_Done = 1.
  - o_Error <= (acc != check byte).
  - o_Length_Error <= (count != LEN).
  - Next state IDLE.
  - Both error flags hold until the next header is accepted.
- Skid/output path:
  - Each cycle, if skid non-empty and !i_Sig_Fifo_Full: pop head into o_Output_Data and set o_Output_Write=1 next cycle. Otherwise o_Output_Write=0 and o_Output_Data holds.
  - Simultaneous push and pop are allowed (count unchanged). Pointers wrap modulo SKID_DEPTH.
  - Latency: accept at edge k gives a FIFO write in the cycle after edge k+1 when empty and not stalled.
  - Byte order is preserved exactly; the check byte is forwarded as the last byte.
- Zero-length packet (LEN=0): header immediately followed by check byte is legal. Checksum = header.
- Stall: i_Sig_Fifo_Full high for any duration loses no data. o_Busy rises exactly when SKID_DEPTH bytes are held.

Test Plan:
- XOR mode, header 8'h0D (LEN=3, addr 1), payload 11,22,33, check 8'h0D^11^22^33=8'h0D, no stalls -> 5 writes in order, one o_Sig_Parity_Done pulse, o_Error=0, o_Length_Error=0.
- Same packet with check byte 8'hFF -> o_Error=1 at done, cleared when next header accepted.
- CHECK_MODE=1, header 8'h08 (LEN=2), payload F0,20, check 8'h18 -> o_Error=0. Check 8'h19 -> o_Error=1.
- Header LEN=2 but 3 payload bytes -> o_Length_Error=1, o_Error per checksum.
- i_Sig_Fifo_Full held 10 cycles mid-packet, SKID_DEPTH=4 -> o_Busy high after 4 buffered bytes. Extra valid byte sets o_Overflow. After release, all accepted bytes are written in order.
- reset asserted during PAYLOAD with 3 bytes buffered -> next cycle all outputs 0, no writes, no done pulse. Following packet processes normally.
